// File: rtl/vram_blit_pkg.sv
// vram_blit_pkg: register map, control bits and FSM states of the video RAM blitter.
package vram_blit_pkg;
   localparam int AW_DEF = 13;
   localparam logic [2:0] REG_SRC_L = 3'd0;
   localparam logic [2:0] REG_SRC_H = 3'd1;
   localparam logic [2:0] REG_DST_L = 3'd2;
   localparam logic [2:0] REG_DST_H = 3'd3;
   localparam logic [2:0] REG_LEN_L = 3'd4;
   localparam logic [2:0] REG_LEN_H = 3'd5;
   localparam logic [2:0] REG_FILL  = 3'd6;
   localparam logic [2:0] REG_CTRL  = 3'd7;
   localparam int CTRL_START = 0;
   localparam int CTRL_MODE  = 1;
   localparam int CTRL_IEN   = 2;
   localparam int CTRL_DIR   = 3;
   localparam int CTRL_ABORT = 4;
   typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, DONE} state_e;
endpackage

// File: rtl/vram_blit_regs.sv
// vram_blit_regs: CPU register file, status readback, done/irq and start/abort pulses.
module vram_blit_regs
   import vram_blit_pkg::*;
#(
   parameter int AW = AW_DEF
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          sel_i,
   input  logic          we_i,
   input  logic [2:0]    addr_i,
   input  logic [7:0]    din_i,
   input  logic          busy_i,
   input  logic          done_set_i,
   output logic [7:0]    dout_o,
   output logic          irq_o,
   output logic [AW-1:0] src_o,
   output logic [AW-1:0] dst_o,
   output logic [AW-1:0] len_o,
   output logic [7:0]    fill_o,
   output logic          mode_o,
   output logic          dir_o,
   output logic          start_o,
   output logic          abort_o
);
   logic [AW-1:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
   logic [7:0] fill_q, fill_d, dout_q, dout_d, rdata;
   logic mode_q, mode_d, dir_q, dir_d, ien_q, ien_d, done_q, done_d;
   logic wr, rd, ctrl_wr, stat_rd;
   always_comb begin
      wr = sel_i & we_i;
      rd = sel_i & ~we_i;
      ctrl_wr = wr & (addr_i == REG_CTRL);
      stat_rd = rd & (addr_i == REG_CTRL);
      start_o = ctrl_wr & din_i[CTRL_START] & ~busy_i;
      abort_o = ctrl_wr & din_i[CTRL_ABORT] & busy_i;
      src_d = src_q;
      dst_d = dst_q;
      len_d = len_q;
      fill_d = fill_q;
      mode_d = mode_q;
      dir_d = dir_q;
      ien_d = ctrl_wr ? din_i[CTRL_IEN] : ien_q;
      if (wr & ~busy_i) begin
         case (addr_i)
            REG_SRC_L: src_d[7:0] = din_i;
            REG_SRC_H: src_d[AW-1:8] = din_i[AW-9:0];
            REG_DST_L: dst_d[7:0] = din_i;
            REG_DST_H: dst_d[AW-1:8] = din_i[AW-9:0];
            REG_LEN_L: len_d[7:0] = din_i;
            REG_LEN_H: len_d[AW-1:8] = din_i[AW-9:0];
            REG_FILL:  fill_d = din_i;
            default: begin
               mode_d = din_i[CTRL_MODE];
               dir_d = din_i[CTRL_DIR];
            end
         endcase
      end
      // completion beats the clear so a zero-length start still reports done
      done_d = done_set_i ? 1'b1 : (start_o | stat_rd) ? 1'b0 : done_q;
      case (addr_i)
         REG_SRC_L: rdata = src_q[7:0];
         REG_SRC_H: rdata = {{(16-AW){1'b0}}, src_q[AW-1:8]};
         REG_DST_L: rdata = dst_q[7:0];
         REG_DST_H: rdata = {{(16-AW){1'b0}}, dst_q[AW-1:8]};
         REG_LEN_L: rdata = len_q[7:0];
         REG_LEN_H: rdata = {{(16-AW){1'b0}}, len_q[AW-1:8]};
         REG_FILL:  rdata = fill_q;
         default:   rdata = {busy_i, done_q, 2'b00, dir_q, ien_q, mode_q, 1'b0};
      endcase
      dout_d = rd ? rdata : dout_q;
   end
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         src_q <= '0;
         dst_q <= '0;
         len_q <= '0;
         fill_q <= '0;
         mode_q <= 1'b0;
         dir_q <= 1'b0;
         ien_q <= 1'b0;
         done_q <= 1'b0;
         dout_q <= '0;
      end else begin
         src_q <= src_d;
         dst_q <= dst_d;
         len_q <= len_d;
         fill_q <= fill_d;
         mode_q <= mode_d;
         dir_q <= dir_d;
         ien_q <= ien_d;
         done_q <= done_d;
         dout_q <= dout_d;
      end
   end
   assign dout_o = dout_q;
   assign irq_o = done_q & ien_q;
   assign src_o = src_q;
   assign dst_o = dst_q;
   assign len_o = len_q;
   assign fill_o = fill_q;
   assign mode_o = mode_q;
   assign dir_o = dir_q;
endmodule

// File: rtl/vram_blit.sv
// vram_blit: byte fill/copy engine mastering the CPU-side video RAM port.
module vram_blit
   import vram_blit_pkg::*;
#(
   parameter int AW = AW_DEF
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          sel_i,
   input  logic          we_i,
   input  logic [2:0]    addr_i,
   input  logic [7:0]    din_i,
   output logic [7:0]    dout_o,
   output logic          irq_o,
   output logic          m_req_o,
   input  logic          m_gnt_i,
   output logic          m_we_o,
   output logic [AW-1:0] m_addr_o,
   output logic [7:0]    m_wdata_o,
   input  logic [7:0]    m_rdata_i
);
   localparam logic [AW-1:0] ONE = AW'(1);
   state_e state_q, state_d;
   logic [AW-1:0] src_q, src_d, dst_q, dst_d, cnt_q, cnt_d, r_src, r_dst, r_len;
   logic [7:0] lat_q, lat_d, r_fill;
   logic r_mode, r_dir, start, abort, busy;
   function automatic logic [AW-1:0] step(input logic [AW-1:0] a, input logic dn);
      return dn ? a - ONE : a + ONE;
   endfunction
   vram_blit_regs #(.AW(AW)) u_regs (
      .clk_i(clk_i), .reset_i(reset_i), .sel_i(sel_i), .we_i(we_i), .addr_i(addr_i),
      .din_i(din_i), .busy_i(busy), .done_set_i(state_d == DONE), .dout_o(dout_o),
      .irq_o(irq_o), .src_o(r_src), .dst_o(r_dst), .len_o(r_len), .fill_o(r_fill),
      .mode_o(r_mode), .dir_o(r_dir), .start_o(start), .abort_o(abort)
   );
   always_comb begin
      state_d = state_q;
      src_d = src_q;
      dst_d = dst_q;
      cnt_d = cnt_q;
      lat_d = lat_q;
      busy = (state_q == RD) | (state_q == RWAIT) | (state_q == WR);
      m_req_o = (state_q == RD) | (state_q == WR);
      m_we_o = state_q == WR;
      m_addr_o = state_q == RD ? src_q : state_q == WR ? dst_q : '0;
      m_wdata_o = state_q != WR ? 8'h00 : r_mode ? lat_q : r_fill;
      case (state_q)
         IDLE: if (start) begin
            src_d = r_src;
            dst_d = r_dst;
            cnt_d = r_len;
            // mode is being written in this very cycle, so take it from the bus
            state_d = r_len == '0 ? DONE : din_i[CTRL_MODE] ? RD : WR;
         end
         RD: state_d = abort ? DONE : m_gnt_i ? RWAIT : RD;
         RWAIT: begin
            lat_d = m_rdata_i;
            src_d = step(src_q, r_dir);
            state_d = abort ? DONE : WR;
         end
         WR: begin
            if (m_gnt_i) begin
               dst_d = step(dst_q, r_dir);
               cnt_d = cnt_q - ONE;
            end
            state_d = abort ? DONE : !m_gnt_i ? WR : cnt_q == ONE ? DONE : r_mode ? RD : WR;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         src_q <= '0;
         dst_q <= '0;
         cnt_q <= '0;
         lat_q <= '0;
      end else begin
         state_q <= state_d;
         src_q <= src_d;
         dst_q <= dst_d;
         cnt_q <= cnt_d;
         lat_q <= lat_d;
      end
   end
endmodule
